// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types: scoreboard entry layout, forward-select encoding
// and default result-availability positions.
package pipeline_pkg;

    // Entry fields are sized for the widest configuration; instances zero-extend into them.
    localparam int SB_RD_W    = 8;
    localparam int SB_AVAIL_W = 8;

    typedef logic [SB_AVAIL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = '0;

    localparam int ALU_AVAIL  = 1;
    localparam int LOAD_AVAIL = 2;

    typedef struct packed {
        logic                  valid;
        logic [SB_RD_W-1:0]    rd;
        logic                  we;
        logic [SB_AVAIL_W-1:0] avail;
    } sb_entry_t;

endpackage

// File: rtl/hazard_operand_match.sv
// Youngest-producer search for one source operand over the in-flight scoreboard,
// resolved into a forward select or a hazard request.
module hazard_operand_match
    import pipeline_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int REG_ADDR_W = 5,
    parameter int FORWARD_EN = 1,
    parameter int WB_BYPASS  = 1,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  sb_entry_t             entries [DEPTH],
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    output logic [SEL_W-1:0]      fwd_sel,
    output logic                  hazard
);

    logic [DEPTH-1:0]      hit;
    logic                  operand_live;
    logic                  found;
    int                    win_pos;
    logic [SB_AVAIL_W-1:0] win_avail;

    // x0 is hard-wired zero, so it never depends on an in-flight write.
    assign operand_live = use_rs && (rs != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = operand_live
                      && entries[gi].valid
                      && entries[gi].we
                      && (entries[gi].rd == SB_RD_W'(rs));
    end

    // Scan oldest to youngest so the lowest position is the last one written.
    always_comb begin
        found     = 1'b0;
        win_pos   = 0;
        win_avail = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found     = 1'b1;
                win_pos   = k + 1;
                win_avail = entries[k].avail;
            end
        end
    end

    // A producer that has reached its avail position has its result on the bypass network.
    always_comb begin
        fwd_sel = SEL_W'(FWD_REGFILE);
        hazard  = 1'b0;
        if (found) begin
            if ((FORWARD_EN != 0) && (win_pos >= int'(win_avail))) begin
                fwd_sel = SEL_W'(win_pos);
            end else if ((WB_BYPASS != 0) && (win_pos == DEPTH)) begin
                fwd_sel = SEL_W'(FWD_REGFILE);
            end else begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// In-order pipeline hazard unit: DEPTH-deep scoreboard of in-flight writes driving
// stall, per-operand forwarding selects, branch squash and a saturating stall counter.
module hazard_scoreboard_unit
    import pipeline_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int REG_ADDR_W = 5,
    parameter int FORWARD_EN = 1,
    parameter int WB_BYPASS  = 1,
    parameter int BR_STAGE   = 2,
    parameter int CNT_W      = 32,
    localparam int AV_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_enable,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_reg_we,
    input  logic [AV_W-1:0]       issue_avail,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic [AV_W-1:0]       fwd_sel_a,
    output logic [AV_W-1:0]       fwd_sel_b,
    output logic                  squash,
    output logic [DEPTH-1:0]      stage_valid,
    output logic [CNT_W-1:0]      stall_count
);

    sb_entry_t        sb_reg  [DEPTH];
    sb_entry_t        sb_next [DEPTH];
    sb_entry_t        issue_entry;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] stall_count_next;
    logic             hazard_a;
    logic             hazard_b;
    logic             issue_accept;

    // Array index k holds scoreboard position k+1.
    assign squash = branch_taken && sb_reg[BR_STAGE-1].valid;

    hazard_operand_match #(
        .DEPTH      (DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .FORWARD_EN (FORWARD_EN),
        .WB_BYPASS  (WB_BYPASS)
    ) u_match_a (
        .entries (sb_reg),
        .rs      (issue_rs1),
        .use_rs  (issue_use_rs1),
        .fwd_sel (fwd_sel_a),
        .hazard  (hazard_a)
    );

    hazard_operand_match #(
        .DEPTH      (DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .FORWARD_EN (FORWARD_EN),
        .WB_BYPASS  (WB_BYPASS)
    ) u_match_b (
        .entries (sb_reg),
        .rs      (issue_rs2),
        .use_rs  (issue_use_rs2),
        .fwd_sel (fwd_sel_b),
        .hazard  (hazard_b)
    );

    assign stall        = issue_valid && !squash && (hazard_a || hazard_b);
    assign issue_accept = issue_valid && !stall && !squash;

    always_comb begin
        issue_entry = '0;
        if (issue_accept) begin
            issue_entry.valid = 1'b1;
            issue_entry.rd    = SB_RD_W'(issue_rd);
            issue_entry.we    = issue_reg_we;
            issue_entry.avail = SB_AVAIL_W'(issue_avail);
        end
    end

    // Younger-than-branch entries are killed as they shift; the branch itself survives.
    always_comb begin
        sb_next[0] = issue_entry;
        for (int k = 1; k < DEPTH; k++) begin
            sb_next[k] = sb_reg[k-1];
            if (squash && (k < BR_STAGE)) begin
                sb_next[k].valid = 1'b0;
            end
        end
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall && (stall_count_reg != '1)) begin
            stall_count_next = stall_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_reg[k] <= '0;
            end
            stall_count_reg <= '0;
        end else if (clk_enable) begin
            sb_reg          <= sb_next;
            stall_count_reg <= stall_count_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_valid
        assign stage_valid[gi] = sb_reg[gi].valid;
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: forwarding instance (table-driven), no-forward instance and a
// deep narrow-counter instance for freeze, mid-stall reset and saturation sequences.
module tb_hazard_scoreboard_unit;
    import pipeline_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic [4:0] avail;
        logic       br;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic [4:0]  fa;
        logic [4:0]  fb;
        logic        sq;
        logic [23:0] sv;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    in_t  in_a, in_b, in_c;

    logic        stall_a, squash_a, stall_b, squash_b, stall_c, squash_c;
    logic [2:0]  fa_a, fb_a, fa_b, fb_b;
    logic [4:0]  fa_c, fb_c;
    logic [3:0]  sv_a, sv_b;
    logic [23:0] sv_c;
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tab_a[15];

    hazard_scoreboard_unit #(.DEPTH(4), .REG_ADDR_W(5), .FORWARD_EN(1), .WB_BYPASS(1),
                             .BR_STAGE(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .clk_enable(in_a.en), .issue_valid(in_a.valid),
        .issue_rs1(in_a.rs1), .issue_rs2(in_a.rs2), .issue_use_rs1(in_a.u1),
        .issue_use_rs2(in_a.u2), .issue_rd(in_a.rd), .issue_reg_we(in_a.we),
        .issue_avail(in_a.avail[2:0]), .branch_taken(in_a.br), .stall(stall_a),
        .fwd_sel_a(fa_a), .fwd_sel_b(fb_a), .squash(squash_a), .stage_valid(sv_a),
        .stall_count(cnt_a));

    hazard_scoreboard_unit #(.DEPTH(4), .REG_ADDR_W(5), .FORWARD_EN(0), .WB_BYPASS(1),
                             .BR_STAGE(2), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .clk_enable(in_b.en), .issue_valid(in_b.valid),
        .issue_rs1(in_b.rs1), .issue_rs2(in_b.rs2), .issue_use_rs1(in_b.u1),
        .issue_use_rs2(in_b.u2), .issue_rd(in_b.rd), .issue_reg_we(in_b.we),
        .issue_avail(in_b.avail[2:0]), .branch_taken(in_b.br), .stall(stall_b),
        .fwd_sel_a(fa_b), .fwd_sel_b(fb_b), .squash(squash_b), .stage_valid(sv_b),
        .stall_count(cnt_b));

    hazard_scoreboard_unit #(.DEPTH(24), .REG_ADDR_W(5), .FORWARD_EN(0), .WB_BYPASS(1),
                             .BR_STAGE(2), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .clk_enable(in_c.en), .issue_valid(in_c.valid),
        .issue_rs1(in_c.rs1), .issue_rs2(in_c.rs2), .issue_use_rs1(in_c.u1),
        .issue_use_rs2(in_c.u2), .issue_rd(in_c.rd), .issue_reg_we(in_c.we),
        .issue_avail(in_c.avail), .branch_taken(in_c.br), .stall(stall_c),
        .fwd_sel_a(fa_c), .fwd_sel_b(fb_c), .squash(squash_c), .stage_valid(sv_c),
        .stall_count(cnt_c));

    function automatic in_t mk_in(int en, int v, int rs1, int u1, int rs2, int u2,
                                  int rd, int we, int av, int br);
        in_t r;
        r.rst = 1'b0;  r.en = 1'(en);   r.valid = 1'(v);
        r.rs1 = 5'(rs1); r.u1 = 1'(u1); r.rs2 = 5'(rs2); r.u2 = 1'(u2);
        r.rd = 5'(rd); r.we = 1'(we);   r.avail = 5'(av); r.br = 1'(br);
        return r;
    endfunction

    function automatic exp_t mk_exp(int st, int fa, int fb, int sq, int sv, int cnt);
        exp_t r;
        r.stall = 1'(st); r.fa = 5'(fa); r.fb = 5'(fb); r.sq = 1'(sq);
        r.sv = 24'(sv);   r.cnt = 32'(cnt);
        return r;
    endfunction

    function automatic exp_t actual(int which);
        exp_t r;
        case (which)
            0: begin
                r.stall = stall_a; r.fa = 5'(fa_a); r.fb = 5'(fb_a); r.sq = squash_a;
                r.sv = 24'(sv_a);  r.cnt = cnt_a;
            end
            1: begin
                r.stall = stall_b; r.fa = 5'(fa_b); r.fb = 5'(fb_b); r.sq = squash_b;
                r.sv = 24'(sv_b);  r.cnt = cnt_b;
            end
            default: begin
                r.stall = stall_c; r.fa = fa_c; r.fb = fb_c; r.sq = squash_c;
                r.sv = sv_c;       r.cnt = 32'(cnt_c);
            end
        endcase
        return r;
    endfunction

    // Drive one s0 cycle after the edge, queue its expectation, check before the next edge.
    task automatic apply(input int which, input in_t v, input exp_t e, input string label);
        exp_t got, want;
        @(posedge clk);
        #1;
        rst = v.rst;
        case (which)
            0:       in_a = v;
            1:       in_b = v;
            default: in_c = v;
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        got  = actual(which);
        want = exp_q.pop_front();
        n_cmp++;
        $display("[%0t] %s: stall=%0b fa=%0d fb=%0d squash=%0b valid=%h count=%0d",
                 $time, label, got.stall, got.fa, got.fb, got.sq, got.sv, got.cnt);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got stall=%0b fa=%0d fb=%0d squash=%0b valid=%h count=%0d, want stall=%0b fa=%0d fb=%0d squash=%0b valid=%h count=%0d",
                     label, got.stall, got.fa, got.fb, got.sq, got.sv, got.cnt,
                     want.stall, want.fa, want.fb, want.sq, want.sv, want.cnt);
        end
    endtask

    initial begin
        in_t  idle, rd_x5, rd_x6, rd_x4, rst_hold;
        exp_t zero;

        idle  = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero  = mk_exp(0, 0, 0, 0, 0, 0);
        in_a  = idle; in_b = idle; in_c = idle;
        rst   = 1'b1;

        //                 en v rs1 u1 rs2 u2 rd we avail       br      st fa fb sq sv     cnt
        tab_a[0]  = '{mk_in(1, 1, 1, 0, 2, 0, 5, 1, ALU_AVAIL,  0), mk_exp(0, 0, 0, 0, 4'b0000, 0)};
        tab_a[1]  = '{mk_in(1, 1, 5, 1, 0, 0, 6, 1, ALU_AVAIL,  0), mk_exp(0, 1, 0, 0, 4'b0001, 0)};
        tab_a[2]  = '{mk_in(1, 1, 0, 0, 0, 0, 7, 1, LOAD_AVAIL, 0), mk_exp(0, 0, 0, 0, 4'b0011, 0)};
        tab_a[3]  = '{mk_in(1, 1, 0, 0, 7, 1, 8, 1, ALU_AVAIL,  0), mk_exp(1, 0, 0, 0, 4'b0111, 0)};
        tab_a[4]  = '{mk_in(1, 1, 0, 0, 7, 1, 8, 1, ALU_AVAIL,  0), mk_exp(0, 0, 2, 0, 4'b1110, 1)};
        tab_a[5]  = '{mk_in(1, 1, 0, 0, 0, 0, 0, 1, ALU_AVAIL,  0), mk_exp(0, 0, 0, 0, 4'b1101, 1)};
        tab_a[6]  = '{mk_in(1, 1, 0, 1, 0, 1, 9, 1, ALU_AVAIL,  0), mk_exp(0, 0, 0, 0, 4'b1011, 1)};
        tab_a[7]  = '{mk_in(1, 1, 0, 0, 0, 0, 9, 1, ALU_AVAIL,  0), mk_exp(0, 0, 0, 0, 4'b0111, 1)};
        tab_a[8]  = '{mk_in(1, 1, 9, 1, 8, 1, 10, 0, ALU_AVAIL, 0), mk_exp(0, 1, 4, 0, 4'b1111, 1)};
        tab_a[9]  = '{mk_in(1, 1, 10, 1, 9, 1, 11, 1, LOAD_AVAIL, 0), mk_exp(0, 0, 2, 0, 4'b1111, 1)};
        tab_a[10] = '{mk_in(1, 1, 11, 1, 0, 0, 13, 1, ALU_AVAIL, 1), mk_exp(0, 0, 0, 1, 4'b1111, 1)};
        tab_a[11] = '{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0),          mk_exp(0, 0, 0, 0, 4'b1100, 1)};
        tab_a[12] = '{mk_in(1, 1, 0, 0, 0, 0, 12, 1, ALU_AVAIL, 1), mk_exp(0, 0, 0, 0, 4'b1000, 1)};
        tab_a[13] = '{mk_in(0, 1, 12, 1, 0, 0, 14, 1, ALU_AVAIL, 0), mk_exp(0, 1, 0, 0, 4'b0001, 1)};
        tab_a[14] = '{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0),          mk_exp(0, 0, 0, 0, 4'b0001, 1)};

        repeat (2) @(posedge clk);
        apply(0, idle, zero, "A reset");
        apply(1, idle, zero, "B reset");
        apply(2, idle, zero, "C reset");

        for (int n = 0; n < 15; n++) begin
            apply(0, tab_a[n].i, tab_a[n].e, $sformatf("A vec %0d", n));
        end

        // No forwarding: reader of an ALU result waits until the producer reaches writeback.
        rd_x5 = mk_in(1, 1, 5, 1, 0, 0, 6, 1, ALU_AVAIL, 0);
        apply(1, mk_in(1, 1, 0, 0, 0, 0, 5, 1, ALU_AVAIL, 0), mk_exp(0, 0, 0, 0, 4'b0000, 0), "B issue x5");
        apply(1, rd_x5, mk_exp(1, 0, 0, 0, 4'b0001, 0), "B stall k1");
        apply(1, rd_x5, mk_exp(1, 0, 0, 0, 4'b0010, 1), "B stall k2");
        apply(1, rd_x5, mk_exp(1, 0, 0, 0, 4'b0100, 2), "B stall k3");
        apply(1, rd_x5, mk_exp(0, 0, 0, 0, 4'b1000, 3), "B wb bypass");
        apply(1, mk_in(1, 0, 6, 1, 0, 0, 0, 0, 0, 0), mk_exp(0, 0, 0, 0, 4'b0001, 3), "B invalid s0");

        // Freeze during a stall, then a synchronous reset with clk_enable low.
        rd_x6 = mk_in(1, 1, 6, 1, 0, 0, 7, 1, ALU_AVAIL, 0);
        apply(1, rd_x6, mk_exp(1, 0, 0, 0, 4'b0010, 3), "B stall k2");
        rd_x6.en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            apply(1, rd_x6, mk_exp(1, 0, 0, 0, 4'b0100, 4), $sformatf("B frozen %0d", n));
        end
        rst_hold     = rd_x6;
        rst_hold.rst = 1'b1;
        apply(1, rst_hold, mk_exp(1, 0, 0, 0, 4'b0100, 4), "B rst asserted");
        rd_x6.en = 1'b1;
        apply(1, rd_x6, zero, "B after rst");
        apply(1, idle, mk_exp(0, 0, 0, 0, 4'b0001, 0), "B post issue");

        // Deep scoreboard gives 23 back-to-back stalls against a 4-bit counter.
        rd_x4 = mk_in(1, 1, 4, 1, 0, 0, 0, 0, ALU_AVAIL, 0);
        apply(2, mk_in(1, 1, 0, 0, 0, 0, 4, 1, ALU_AVAIL, 0), zero, "C issue x4");
        for (int n = 0; n < 24; n++) begin
            apply(2, rd_x4, mk_exp((n < 23) ? 1 : 0, 0, 0, 0, 1 << n, (n > 15) ? 15 : n),
                  $sformatf("C sat %0d", n));
        end
        apply(2, idle, mk_exp(0, 0, 0, 0, 1, 15), "C hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
